frame_acc: RTL and testbench

FRAME_ACC -- requirements
Module: frame_acc

---
 rtl/frame_acc.sv | 108 ++++++++++
 tb/tb_frame_acc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_acc.sv
// Frame accumulator: sums unsigned samples and counts them until a frame
// closes, then hands {sum, count, saturated} to the downstream divider
// through a single-entry output slot with valid/ready handshaking.
`timescale 1ns/1ps

module frame_acc #(
    parameter int aw = 18,
    parameter int bw = 10,
    parameter int sw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [sw-1:0] in_data,
    input  logic          in_last,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [aw-1:0] out_sum,
    output logic [bw-1:0] out_cnt,
    output logic          out_sat
);

    typedef enum logic {EMPTY, ACC} frame_state_t;
    typedef enum logic {FREE, FULL} slot_state_t;

    frame_state_t  frame_state;
    slot_state_t   slot_state;

    logic [aw-1:0] acc_sum;
    logic [bw-1:0] acc_cnt;
    logic          acc_sat;

    logic          accept;
    logic          close;
    logic [aw-1:0] base_sum;
    logic [bw-1:0] base_cnt;
    logic [aw:0]   sum_ext;
    logic [aw-1:0] sum_next;
    logic [bw-1:0] cnt_next;
    logic          sat_next;

    // The slot can take a new result when it is empty or being drained this beat.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (slot_state == FULL);

    // Post-update frame totals; a carry out of the sum pins it at all-ones and marks saturation.
    always_comb begin
        base_sum = (frame_state == ACC) ? acc_sum : '0;
        base_cnt = (frame_state == ACC) ? acc_cnt : '0;
        sum_ext  = {1'b0, base_sum} + {{(aw + 1 - sw){1'b0}}, in_data};
        sum_next = base_sum;
        cnt_next = base_cnt;
        sat_next = acc_sat;
        if (accept) begin
            if (sum_ext[aw]) begin
                sum_next = '1;
                sat_next = 1'b1;
            end else begin
                sum_next = sum_ext[aw-1:0];
            end
            cnt_next = base_cnt + bw'(1);
        end
    end

    // A frame closes on a last sample, on a full counter, or on a flush while the slot can take it.
    assign close = (accept && (in_last || (cnt_next == '1))) || (flush && in_ready);

    // Frame FSM: accumulate accepted samples, restart from zero on every close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_state <= EMPTY;
            acc_sum     <= '0;
            acc_cnt     <= '0;
            acc_sat     <= 1'b0;
        end else if (close) begin
            frame_state <= EMPTY;
            acc_sum     <= '0;
            acc_cnt     <= '0;
            acc_sat     <= 1'b0;
        end else if (accept) begin
            frame_state <= ACC;
            acc_sum     <= sum_next;
            acc_cnt     <= cnt_next;
            acc_sat     <= sat_next;
        end
    end

    // Output slot: load on close (even while draining the previous result), free on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_state <= FREE;
            out_sum    <= '0;
            out_cnt    <= '0;
            out_sat    <= 1'b0;
        end else if (close) begin
            slot_state <= FULL;
            out_sum    <= sum_next;
            out_cnt    <= cnt_next;
            out_sat    <= sat_next;
        end else if (out_ready) begin
            slot_state <= FREE;
        end
    end

endmodule

// File: tb/tb_frame_acc.sv
// Testbench for frame_acc: a behavioural model feeds a result scoreboard,
// a table of single beats covers ordinary frames, and hand-written
// sequences cover backpressure, auto-close, flush, reset and saturation.
`timescale 1ns/1ps

module tb_frame_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [17:0] out_sum;
    logic [9:0]  out_cnt;
    logic        out_sat;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [9:0]  out_sum_s;
    logic [9:0]  out_cnt_s;
    logic        out_sat_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [17:0] sum;
        logic [9:0]  cnt;
        logic        sat;
    } result_t;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        f;
        logic        exp_valid;
        logic [17:0] exp_sum;
        logic [9:0]  exp_cnt;
        logic        exp_sat;
    } vec_t;

    result_t exp_q[$];

    int   m_sum;
    int   m_cnt;
    logic m_sat;
    logic m_ov;

    frame_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_sat   (out_sat)
    );

    frame_acc #(.aw(10), .bw(10), .sw(8)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .in_last   (in_last),
        .flush     (flush),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_sum   (out_sum_s),
        .out_cnt   (out_cnt_s),
        .out_sat   (out_sat_s)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic l, input logic f);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_out_sum", out_sum, 0);
        check_output("rst_out_cnt", out_cnt, 0);
        check_output("rst_out_sat", out_sat, 0);
        #2 rst = 1'b0;
    endtask

    // Reference model of the aw=18/bw=10 instance; pushes each closed frame to the scoreboard.
    always @(posedge clk or posedge rst) begin : model
        int   ns;
        int   nc;
        logic nsat;
        logic rdy;
        logic acc;
        logic cls;
        if (rst) begin
            m_sum = 0;
            m_cnt = 0;
            m_sat = 1'b0;
            m_ov  = 1'b0;
            exp_q.delete();
        end else begin
            rdy  = !m_ov || out_ready;
            acc  = in_valid && rdy;
            ns   = m_sum;
            nc   = m_cnt;
            nsat = m_sat;
            if (acc) begin
                ns = m_sum + int'(in_data);
                if (ns > 262143) begin
                    ns   = 262143;
                    nsat = 1'b1;
                end
                nc = m_cnt + 1;
            end
            cls = (acc && (in_last || nc == 1023)) || (flush && rdy);
            if (cls) begin
                exp_q.push_back('{ns[17:0], nc[9:0], nsat});
                m_sum = 0;
                m_cnt = 0;
                m_sat = 1'b0;
                m_ov  = 1'b1;
            end else begin
                m_sum = ns;
                m_cnt = nc;
                m_sat = nsat;
                if (m_ov && out_ready) m_ov = 1'b0;
            end
        end
    end

    // Scoreboard: compare handshake signals every cycle and held results against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            check_output("sb_out_valid", out_valid, m_ov);
            check_output("sb_in_ready", in_ready, !m_ov || out_ready);
            if (m_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got result, expected none at %0t", $time);
                end else begin
                    check_output("sb_out_sum", out_sum, exp_q[0].sum);
                    check_output("sb_out_cnt", out_cnt, exp_q[0].cnt);
                    check_output("sb_out_sat", out_sat, exp_q[0].sat);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        vec_t vecs[8];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b0, 18'd0,   10'd0, 1'b0};
        vecs[1] = '{1'b1, 8'd20,  1'b0, 1'b0, 1'b0, 18'd0,   10'd0, 1'b0};
        vecs[2] = '{1'b1, 8'd30,  1'b0, 1'b0, 1'b0, 18'd0,   10'd0, 1'b0};
        vecs[3] = '{1'b1, 8'd40,  1'b1, 1'b0, 1'b1, 18'd100, 10'd4, 1'b0};
        vecs[4] = '{1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 18'd0,   10'd1, 1'b0};
        vecs[5] = '{1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 18'd0,   10'd0, 1'b0};
        vecs[6] = '{1'b1, 8'd1,   1'b1, 1'b0, 1'b1, 18'd256, 10'd2, 1'b0};
        vecs[7] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 18'd0,   10'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_out_sum", out_sum, 0);
        check_output("reset_out_cnt", out_cnt, 0);
        check_output("reset_out_sat", out_sat, 0);
        rst = 1'b0;

        // Table of single beats with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f);
            check_output($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d_out_sum", i), out_sum, vecs[i].exp_sum);
                check_output($sformatf("vec%0d_out_cnt", i), out_cnt, vecs[i].exp_cnt);
                check_output($sformatf("vec%0d_out_sat", i), out_sat, vecs[i].exp_sat);
            end
        end

        // Flush of an empty frame, then flush together with a sample in ACC.
        apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);
        check_output("flush_empty_valid", out_valid, 1);
        check_output("flush_empty_cnt", out_cnt, 0);
        check_output("flush_empty_sum", out_sum, 0);
        apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'd7, 1'b0, 1'b1);
        check_output("flush_sample_valid", out_valid, 1);
        check_output("flush_sample_sum", out_sum, 10);
        check_output("flush_sample_cnt", out_cnt, 2);

        // Backpressure: result held and input stalled while out_ready is low.
        apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
        out_ready = 1'b0;
        apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'd2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 8'd99, 1'b1, 1'b1);
            check_output("bp_in_ready", in_ready, 0);
            check_output("bp_out_valid", out_valid, 1);
            check_output("bp_out_sum", out_sum, 3);
            check_output("bp_out_cnt", out_cnt, 2);
        end
        out_ready = 1'b1;
        apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
        check_output("bp_drained_valid", out_valid, 0);
        check_output("bp_drained_ready", in_ready, 1);

        // Auto-close after 1023 samples, then a fresh single-sample frame.
        for (int i = 0; i < 1023; i++) apply_stimulus(1'b1, 8'd255, 1'b0, 1'b0);
        check_output("auto_valid", out_valid, 1);
        check_output("auto_cnt", out_cnt, 1023);
        check_output("auto_sum", out_sum, 260865);
        check_output("auto_sat", out_sat, 0);
        apply_stimulus(1'b1, 8'd255, 1'b1, 1'b0);
        check_output("auto_next_cnt", out_cnt, 1);
        check_output("auto_next_sum", out_sum, 255);

        // Reset mid-frame discards the partial frame.
        apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0);
        pulse_reset();
        apply_stimulus(1'b1, 8'd5, 1'b1, 1'b0);
        check_output("post_rst_valid", out_valid, 1);
        check_output("post_rst_sum", out_sum, 5);
        check_output("post_rst_cnt", out_cnt, 1);

        // Saturation on the narrow instance; the wide one sees the same samples unsaturated.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'd255, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'd255, 1'b1, 1'b0);
        check_output("sat_valid", out_valid_s, 1);
        check_output("sat_sum", out_sum_s, 1023);
        check_output("sat_cnt", out_cnt_s, 5);
        check_output("sat_flag", out_sat_s, 1);
        check_output("sat_in_ready", in_ready_s, 1);
        check_output("wide_sum", out_sum, 1275);
        check_output("wide_sat", out_sat, 0);
        apply_stimulus(1'b1, 8'd1, 1'b1, 1'b0);
        check_output("sat_next_sum", out_sum_s, 1);
        check_output("sat_next_cnt", out_cnt_s, 1);
        check_output("sat_next_flag", out_sat_s, 0);

        apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
        check_output("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
